i2c_slave_reg: RTL



---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_slave_reg_if.sv | 27 ++
 rtl/i2c_bus_sync.sv | 47 ++++
 rtl/i2c_slave_reg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus polarities, field widths and the slave state
// encoding. Used by the slave, the master and the bench.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 4;

  // Acknowledge is signalled by holding sda low during the ninth clock
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } slave_state_t;

  // True when the upper seven bits of an address byte select this device
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [ADDR_W-1:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_slave_reg_if.sv
// Parallel register-side interface of the I2C slave. The slave presents the
// last written nibble and strobes; local logic supplies the read nibble.
interface i2c_slave_reg_if import i2c_pkg::*; ();

  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              wr_valid;
  logic              rd_req;
  logic              busy;

  modport slave (
    input  data_in,
    output data_out,
    output wr_valid,
    output rd_req,
    output busy
  );

  modport master (
    output data_in,
    input  data_out,
    input  wr_valid,
    input  rd_req,
    input  busy
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Brings scl/sda into the i2c_clk domain and derives single-cycle event
// pulses: scl rise/fall plus START/STOP conditions. SYNC_STAGES must be >= 2.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i2c_clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic rise,
  output logic fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_level;

  // Synchronizer chains plus one history flop; reset to the idle-bus level (high)
  always_ff @(posedge i2c_clk) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
      scl_hist <= scl_pipe[SYNC_STAGES-1];
      sda_hist <= sda_pipe[SYNC_STAGES-1];
    end
  end

  assign scl_level = scl_pipe[SYNC_STAGES-1];
  assign sda_level = sda_pipe[SYNC_STAGES-1];

  // START/STOP require scl to be high in both the current and previous sample
  assign rise  =  scl_level & ~scl_hist;
  assign fall  = ~scl_level &  scl_hist;
  assign start =  scl_level &  scl_hist &  sda_hist & ~sda_level;
  assign stop  =  scl_level &  scl_hist & ~sda_hist &  sda_level;

endmodule

// File: rtl/i2c_slave_reg.sv
// I2C slave exposing a single 4-bit register. Decodes START/STOP, matches
// SLAVE_ADDR, acknowledges, and either captures a written nibble or returns
// data_in (latched at the address ACK). sda is only ever pulled low.
module i2c_slave_reg import i2c_pkg::*; #(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h52,
  parameter int                SYNC_STAGES = 2
) (
  input  logic             i2c_clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  i2c_slave_reg_if.slave   regs
);

  logic sda_level;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i2c_clk   (i2c_clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_level (sda_level),
    .rise      (scl_rise),
    .fall      (scl_fall),
    .start     (bus_start),
    .stop      (bus_stop)
  );

  slave_state_t      state, state_next;
  logic [2:0]        addr_cnt, addr_cnt_next;
  logic [1:0]        data_cnt, data_cnt_next;
  logic [6:0]        shift_reg, shift_next;
  logic              rw_bit, rw_next;
  logic [DATA_W-1:0] rd_data, rd_data_next;
  logic              sda_oe, sda_oe_next;
  logic              ack_rose, ack_rose_next;
  logic              busy, busy_next;
  logic [DATA_W-1:0] data_out, data_out_next;
  logic              wr_valid, wr_valid_next;
  logic              rd_req, rd_req_next;

  logic [7:0]        addr_byte;
  logic [1:0]        next_bit_idx;

  // Full address byte as it stands once the current sda sample is shifted in
  assign addr_byte    = {shift_reg, sda_level};
  assign next_bit_idx = data_cnt - 2'd1;

  // State and datapath registers; everything returns to the idle-bus values on reset
  always_ff @(posedge i2c_clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      data_cnt  <= '0;
      shift_reg <= '0;
      rw_bit    <= 1'b0;
      rd_data   <= '0;
      sda_oe    <= 1'b0;
      ack_rose  <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
    end else begin
      state     <= state_next;
      addr_cnt  <= addr_cnt_next;
      data_cnt  <= data_cnt_next;
      shift_reg <= shift_next;
      rw_bit    <= rw_next;
      rd_data   <= rd_data_next;
      sda_oe    <= sda_oe_next;
      ack_rose  <= ack_rose_next;
      busy      <= busy_next;
      data_out  <= data_out_next;
      wr_valid  <= wr_valid_next;
      rd_req    <= rd_req_next;
    end
  end

  // Next-state and datapath decisions; bus START/STOP override any scl edge
  always_comb begin
    state_next    = state;
    addr_cnt_next = addr_cnt;
    data_cnt_next = data_cnt;
    shift_next    = shift_reg;
    rw_next       = rw_bit;
    rd_data_next  = rd_data;
    sda_oe_next   = sda_oe;
    ack_rose_next = ack_rose;
    busy_next     = busy;
    data_out_next = data_out;
    wr_valid_next = 1'b0;
    rd_req_next   = 1'b0;

    if (bus_stop) begin
      state_next    = IDLE;
      sda_oe_next   = 1'b0;
      busy_next     = 1'b0;
      ack_rose_next = 1'b0;
    end else if (bus_start) begin
      state_next    = ADDR;
      addr_cnt_next = 3'd7;
      sda_oe_next   = 1'b0;
      busy_next     = 1'b0;
      ack_rose_next = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shift_next = addr_byte[6:0];
            if (addr_cnt == 3'd0) begin
              if (addr_match(addr_byte, SLAVE_ADDR)) begin
                state_next    = ADDR_ACK;
                busy_next     = 1'b1;
                rw_next       = addr_byte[0];
                ack_rose_next = 1'b0;
                if (addr_byte[0]) begin
                  rd_data_next = regs.data_in;
                  rd_req_next  = 1'b1;
                end
              end else begin
                state_next  = WAIT_STOP;
                sda_oe_next = 1'b0;
              end
            end else begin
              addr_cnt_next = addr_cnt - 3'd1;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_rise && sda_oe) begin
            ack_rose_next = 1'b1;
          end else if (scl_fall) begin
            if (!ack_rose) begin
              sda_oe_next = (ACK == 1'b0);
            end else begin
              ack_rose_next = 1'b0;
              data_cnt_next = 2'd3;
              if (rw_bit) begin
                state_next  = RD_DATA;
                sda_oe_next = ~rd_data[3];
              end else begin
                state_next  = WR_DATA;
                sda_oe_next = 1'b0;
              end
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_next = addr_byte[6:0];
            if (data_cnt == 2'd0) begin
              data_out_next = {shift_reg[2:0], sda_level};
              wr_valid_next = 1'b1;
              state_next    = WR_ACK;
              ack_rose_next = 1'b0;
            end else begin
              data_cnt_next = data_cnt - 2'd1;
            end
          end
        end

        WR_ACK: begin
          if (scl_rise && sda_oe) begin
            ack_rose_next = 1'b1;
          end else if (scl_fall) begin
            if (!ack_rose) begin
              sda_oe_next = (ACK == 1'b0);
            end else begin
              ack_rose_next = 1'b0;
              sda_oe_next   = 1'b0;
              state_next    = WAIT_STOP;
            end
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (data_cnt == 2'd0) begin
              sda_oe_next = 1'b0;
              state_next  = RD_ACK;
            end else begin
              data_cnt_next = next_bit_idx;
              sda_oe_next   = ~rd_data[next_bit_idx];
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            state_next = WAIT_STOP;
          end
        end

        WAIT_STOP: begin
          sda_oe_next = 1'b0;
        end

        default: begin
          state_next  = IDLE;
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

  // Open-drain output: pull low when enabled, otherwise leave the line floating
  assign sda = sda_oe ? ACK : 1'bz;

  assign regs.data_out = data_out;
  assign regs.wr_valid = wr_valid;
  assign regs.rd_req   = rd_req;
  assign regs.busy     = busy;

endmodule
